// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 clock, frames
// 11-bit serial words, and turns make-codes of hex keys 0-9/A-F into a
// 4-bit key value with a one-cycle valid strobe.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a start bit (data=0 on a filtered falling edge)
// S_RECV   | shifting in the 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, then handing the byte to decode
module ps2_key_decoder #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER  > 1) ? $clog2(FILTER + 1)  : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_clk_q, filt_clk_d;
  logic          fall_q;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          frame_err_q, frame_err_d;

  logic          tmo_hit, byte_ok, map_hit;
  logic [3:0]    map_val;

  // Filtered clock flips only after FILTER consecutive samples disagree with it.
  always_comb begin
    filt_cnt_d = '0;
    filt_clk_d = filt_clk_q;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER - 1)) filt_clk_d = clk_s2_q;
      else                               filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  // Synchronizers, glitch filter and registered falling-edge strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_cnt_q <= '0;
      filt_clk_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      filt_cnt_q <= filt_cnt_d;
      filt_clk_q <= filt_clk_d;
      fall_q     <= filt_clk_q & ~filt_clk_d;
    end
  end

  // Make-code lookup for the sixteen hex keys.
  always_comb begin
    map_hit = 1'b1;
    map_val = 4'h0;
    case (shift_q)
      8'h45: map_val = 4'h0;
      8'h16: map_val = 4'h1;
      8'h1E: map_val = 4'h2;
      8'h26: map_val = 4'h3;
      8'h25: map_val = 4'h4;
      8'h2E: map_val = 4'h5;
      8'h36: map_val = 4'h6;
      8'h3D: map_val = 4'h7;
      8'h3E: map_val = 4'h8;
      8'h46: map_val = 4'h9;
      8'h1C: map_val = 4'hA;
      8'h32: map_val = 4'hB;
      8'h21: map_val = 4'hC;
      8'h23: map_val = 4'hD;
      8'h24: map_val = 4'hE;
      8'h2B: map_val = 4'hF;
      default: map_hit = 1'b0;
    endcase
  end

  // Frame FSM, timeout watchdog and break/extended decode.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    byte_ok     = 1'b0;

    // tmo_q holds the number of cycles since the last fall, so the error
    // registers exactly TIMEOUT cycles after that fall.
    tmo_hit = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT - 1));
    if (fall_q)                 tmo_d = TW'(1);
    else if (state_q == S_IDLE) tmo_d = '0;
    else                        tmo_d = tmo_q + 1'b1;

    if (tmo_hit) begin
      // A fall coinciding with the timeout is deliberately dropped.
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      tmo_d       = '0;
      frame_err_d = 1'b1;
    end else if (fall_q) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_RECV;
            bit_cnt_d = '0;
          end
        end
        S_RECV: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) byte_ok     = 1'b1;
          else                                 frame_err_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (byte_ok) begin
      if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q || ext_q) begin
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (map_hit) begin
        key_code_d  = map_val;
        key_valid_d = 1'b1;
      end
    end
  end

  // FSM, decode flags and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: the stimulus side plays PS/2 frames
// and predicts each key/error pulse with its arrival cycle; a monitor pops
// and compares whenever the DUT pulses an output.
module tb_ps2_key_decoder;

  localparam int FILTER  = 4;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 20;
  localparam int LAT     = 2 + FILTER;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key_code;
  logic       key_valid;
  logic       frame_err;

  ps2_key_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [3:0] code;
    int         when;
  } exp_t;

  exp_t       sbq[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         lut[256];
  bit         brk_m = 0, ext_m = 0;
  logic [3:0] model_code = 4'h0;
  logic [3:0] shown_code = 4'h0;
  bit         prev_valid = 0;

  // Reference model of the decode rules.
  function automatic void model_byte(input logic [7:0] b, output bit emit, output logic [3:0] code);
    emit = 0;
    code = model_code;
    if (b == 8'hF0) brk_m = 1;
    else if (b == 8'hE0) ext_m = 1;
    else if (brk_m || ext_m) begin
      brk_m = 0;
      ext_m = 0;
    end else if (lut[b] >= 0) begin
      emit = 1;
      code = 4'(lut[b]);
      model_code = code;
    end
  endfunction

  task automatic ps2_bit(input bit b, input bit push, input bit is_err,
                         input logic [3:0] code, input int offs);
    exp_t e;
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (push) begin
      e.is_err = is_err;
      e.code   = code;
      e.when   = cyc + offs;
      sbq.push_back(e);
    end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    bit         par, emit, err;
    logic [3:0] code;
    par  = (~^b) ^ bad_par;
    err  = bad_par | bad_stop;
    emit = 0;
    code = 4'h0;
    if (!err) model_byte(b, emit, code);
    ps2_bit(1'b0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0, 0, 4'h0, 0);
    ps2_bit(par, 0, 0, 4'h0, 0);
    ps2_bit(~bad_stop, emit | err, err, code, LAT + 1);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_truncated(input logic [7:0] b);
    ps2_bit(1'b0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 3; i++) ps2_bit(b[i], 0, 0, 4'h0, 0);
    ps2_bit(b[3], 1, 1, 4'h0, LAT + TIMEOUT);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 40) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every output pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      vectors++;
      if (key_valid !== 1'b0 || frame_err !== 1'b0 || key_code !== 4'h0) begin
        miscompares++;
        $display("FAIL reset_outputs: got code=%h valid=%b err=%b, want 0/0/0",
                 key_code, key_valid, frame_err);
      end
      prev_valid = 0;
    end else begin
      if (key_valid || frame_err) begin
        vectors++;
        if (key_valid && frame_err) begin
          miscompares++;
          $display("FAIL both_pulses at cycle %0d: valid and err high together", cyc);
        end else if (key_valid && prev_valid) begin
          miscompares++;
          $display("FAIL back_to_back_valid at cycle %0d", cyc);
        end else if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse at cycle %0d: valid=%b err=%b code=%h, want none",
                   cyc, key_valid, frame_err, key_code);
        end else begin
          e = sbq.pop_front();
          if (e.is_err != frame_err || e.when != cyc ||
              (!e.is_err && key_code !== e.code)) begin
            miscompares++;
            $display("FAIL pulse_check: got err=%b code=%h cycle=%0d, want err=%b code=%h cycle=%0d",
                     frame_err, key_code, cyc, e.is_err, e.code, e.when);
          end
          if (!e.is_err) shown_code = e.code;
        end
      end else begin
        vectors++;
        if (key_code !== shown_code) begin
          miscompares++;
          $display("FAIL code_hold at cycle %0d: got %h, want %h", cyc, key_code, shown_code);
        end
      end
      prev_valid = key_valid;
    end
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool[20];
    logic [7:0] b;
    for (int i = 0; i < 256; i++) lut[i] = -1;
    lut[8'h45] = 0;  lut[8'h16] = 1;  lut[8'h1E] = 2;  lut[8'h26] = 3;
    lut[8'h25] = 4;  lut[8'h2E] = 5;  lut[8'h36] = 6;  lut[8'h3D] = 7;
    lut[8'h3E] = 8;  lut[8'h46] = 9;  lut[8'h1C] = 10; lut[8'h32] = 11;
    lut[8'h21] = 12; lut[8'h23] = 13; lut[8'h24] = 14; lut[8'h2B] = 15;
    pool = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
             8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'hF0, 8'hE0, 8'h1D, 8'h5A};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ps2_clk = ~ps2_clk;
    end
    @(negedge clk);
    ps2_clk = 1'b1;
    rst_n = 1'b1;
    repeat (3 * FILTER + 20) @(negedge clk);

    send_frame(8'h16, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h16, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h45, 0, 0);
    send_frame(8'h2E, 0, 0);
    send_frame(8'h26, 1, 0);
    send_frame(8'h26, 0, 0);
    send_truncated(8'h3E);
    send_frame(8'h46, 0, 0);
    send_frame(8'h1D, 0, 0);

    ps2_data = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILTER - 1) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
    send_frame(8'h16, 0, 0);

    for (int n = 0; n < 30; n++) begin
      b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
      send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      repeat ($urandom_range(5, 30)) @(negedge clk);
    end
    send_frame(8'h2B, 0, 0);

    repeat (LAT + 40) @(negedge clk);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expectations: %0d pulses never seen, want 0", sbq.size());
    end
    vectors++;
    if (key_code !== model_code) begin
      miscompares++;
      $display("FAIL final_code: got %h, want %h", key_code, model_code);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
